// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_e;

    // The one signed quotient that cannot be represented: most-negative / -1.
    localparam logic [MD_XLEN-1:0] MD_OVF_DIVIDEND  = 32'h8000_0000;
    localparam logic [MD_XLEN-1:0] MD_OVF_DIVISOR   = 32'hFFFF_FFFF;
    localparam logic [MD_XLEN-1:0] MD_OVF_QUOTIENT  = 32'h8000_0000;
    localparam logic [MD_XLEN-1:0] MD_OVF_REMAINDER = 32'h0000_0000;

    function automatic logic op_a_signed(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic op_b_signed(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage handshake between the core (master) and the M-extension unit (slave).
interface muldiv_if #(parameter int XLEN = muldiv_pkg::MD_XLEN);

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output stall, busy, done, result
    );

endinterface

// File: rtl/muldiv_datapath.sv
// Magnitude shift-add multiplier / restoring divider with final sign correction.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step_mul,
    input  logic            step_div,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] final_val
);

    md_op_e            op_in;
    md_op_e            op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;

    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              neg_ld;
    logic [XLEN:0]     msum;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     rshift;
    logic [XLEN:0]     rdiff;
    logic              fits;
    logic [XLEN-1:0]   rem_nxt;
    logic [XLEN-1:0]   quo_nxt;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign op_in = md_op_e'(funct3);

    always_comb begin
        sign_a = op_a_signed(op_in) & op_a[XLEN-1];
        sign_b = op_b_signed(op_in) & op_b[XLEN-1];
        abs_a  = cond_neg(op_a, sign_a);
        abs_b  = cond_neg(op_b, sign_b);
        // Remainder follows the dividend's sign; product and quotient follow a^b.
        neg_ld = (op_in inside {MD_REM, MD_REMU}) ? sign_a : (sign_a ^ sign_b);

        // opnd holds the multiplicand for MUL and the divisor for DIV.
        msum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_nxt = {msum, acc[XLEN-1:1]};
        prod    = neg_q ? -acc_nxt : acc_nxt;

        rshift  = {rem, quo[XLEN-1]};
        rdiff   = rshift - {1'b0, opnd};
        fits    = (rshift >= {1'b0, opnd});
        rem_nxt = fits ? rdiff[XLEN-1:0] : rshift[XLEN-1:0];
        quo_nxt = {quo[XLEN-2:0], fits};

        // Valid only alongside the final step; the sequencer captures it then.
        final_val = prod[XLEN-1:0];
        case (op_q)
            MD_MULH, MD_MULHSU, MD_MULHU: final_val = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              final_val = cond_neg(quo_nxt, neg_q);
            MD_REM, MD_REMU:              final_val = cond_neg(rem_nxt, neg_q);
            default:                      final_val = prod[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= MD_MUL;
            neg_q <= 1'b0;
            opnd  <= '0;
            acc   <= '0;
            rem   <= '0;
            quo   <= '0;
        end else if (load) begin
            op_q  <= op_in;
            neg_q <= neg_ld;
            opnd  <= funct3[2] ? abs_b : abs_a;
            acc   <= {{XLEN{1'b0}}, abs_b};
            rem   <= '0;
            quo   <= abs_a;
        end else if (step_mul) begin
            acc <= acc_nxt;
        end else if (step_div) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative unit: FSM, iteration counter, special-case divide and pipeline stall.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    localparam int CW = $clog2(XLEN);

    md_state_e       state;
    logic [CW-1:0]   cnt;
    logic            done_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] final_val;

    md_op_e          op_in;
    logic            accept;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_val;

    assign op_in  = md_op_e'(bus.funct3);
    assign accept = (state == IDLE) && bus.start && !bus.flush;

    // Divide-by-zero and signed overflow finish straight from IDLE.
    always_comb begin
        div_zero    = bus.funct3[2] && (bus.op_b == '0);
        div_ovf     = (op_in inside {MD_DIV, MD_REM}) &&
                      (bus.op_a == MD_OVF_DIVIDEND) && (bus.op_b == MD_OVF_DIVISOR);
        special     = div_zero || div_ovf;
        special_val = '0;
        if (div_zero)
            special_val = bus.funct3[1] ? bus.op_a : '1;
        else if (div_ovf)
            special_val = bus.funct3[1] ? MD_OVF_REMAINDER : MD_OVF_QUOTIENT;
    end

    muldiv_datapath #(.XLEN(XLEN)) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .step_mul (state == MUL),
        .step_div (state == DIV),
        .funct3   (bus.funct3),
        .op_a     (bus.op_a),
        .op_b     (bus.op_b),
        .final_val(final_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= CW'(XLEN - 1);
                        if (special) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= special_val;
                        end else begin
                            state <= bus.funct3[2] ? DIV : MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state    <= DONE;
                        done_q   <= 1'b1;
                        result_q <= final_val;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Combinational so the instruction is held from its first execute cycle.
    assign bus.stall  = accept || (state == MUL) || (state == DIV);
    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a plain-arithmetic reference.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    muldiv_if #(.XLEN(32)) bus();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 0;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] exp;
        int          lat;
        int          k;
        int          stalls;
        bit          seen;
        exp = ref_result(f, a, b);
        lat = ref_latency(f, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.flush = 1'b0;
        #1;
        stalls = bus.stall ? 1 : 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0;
        seen = 1'b0;
        while (k <= 40) begin
            if (bus.stall) stalls++;
            if (bus.done) begin seen = 1'b1; break; end
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (!seen || k != lat) begin
            bad++;
            $display("FAIL %s latency: got %0d (done seen %0d) want %0d", name, k, seen, lat);
        end
        total++;
        if (bus.result !== exp) begin
            bad++;
            $display("FAIL %s result: got %h want %h", name, bus.result, exp);
        end
        total++;
        if (stalls != lat + 1) begin
            bad++;
            $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, lat + 1);
        end
        @(posedge clk); #1;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after done: done=%b busy=%b want 0 0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.stall, bus.busy, bus.done} !== 3'b000 || bus.result !== 32'd0) begin
            bad++;
            $display("FAIL reset: stall/busy/done=%b%b%b result=%h want 000 0", bus.stall, bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op(MD_MUL,    32'd7,          32'hFFFF_FFFD, "mul_7_m3");
        run_op(MD_MULH,   32'h8000_0000,  32'h8000_0000, "mulh_min");
        run_op(MD_MULHU,  32'h8000_0000,  32'h8000_0000, "mulhu_min");
        run_op(MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhsu_m1");
        run_op(MD_DIV,    32'hFFFF_FFEC,  32'd3,         "div_m20_3");
        run_op(MD_REM,    32'hFFFF_FFEC,  32'd3,         "rem_m20_3");
        run_op(MD_DIVU,   32'd100,        32'd7,         "divu_100_7");
        run_op(MD_REMU,   32'd100,        32'd7,         "remu_100_7");
        run_op(MD_DIVU,   32'h1234_5678,  32'd0,         "divu_by0");
        run_op(MD_REM,    32'd5,          32'd0,         "rem_by0");
        run_op(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, "div_ovf");
        run_op(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf");
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          mode;
        for (int i = 0; i < 24; i++) begin
            f    = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 7);
            if (mode == 0) b = 32'd0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 2) b = 32'($urandom_range(1, 15));
            run_op(f, a, b, $sformatf("rand%0d_f%0d", i, f));
        end
    endtask

    task automatic test_flush();
        int dones;
        run_op(MD_DIVU, 32'd100, 32'd7, "flush_pre");
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = MD_DIV; bus.op_a = 32'd1000; bus.op_b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle: busy=%b stall=%b want 0 0", bus.busy, bus.stall);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL flush_no_done: got %0d pulses want 0", dones);
        end
        total++;
        if (bus.result !== 32'd14) begin
            bad++;
            $display("FAIL flush_result: got %h want %h", bus.result, 32'd14);
        end
        // Start together with flush must not launch anything.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = MD_MUL; bus.op_a = 32'd3; bus.op_b = 32'd5;
        #1;
        total++;
        if (bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_start_stall: got %b want 0", bus.stall);
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_start_busy: got %b want 0", bus.busy);
        end
        // Flush arriving in DONE leaves the pulse and result alone.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = MD_REMU; bus.op_a = 32'd77; bus.op_b = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b1;
        #3;
        total++;
        if (bus.done !== 1'b1 || bus.result !== 32'd77) begin
            bad++;
            $display("FAIL flush_in_done: done=%b result=%h want 1 %h", bus.done, bus.result, 32'd77);
        end
        @(negedge clk);
        bus.flush = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = MD_MUL; bus.op_a = 32'd7; bus.op_b = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.stall, bus.busy, bus.done} !== 3'b000 || bus.result !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid: stall/busy/done=%b%b%b result=%h want 000 0", bus.stall, bus.busy, bus.done, bus.result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "after_reset");
    endtask

    task automatic test_busy_start();
        int dones;
        logic [31:0] exp;
        exp = ref_result(MD_MUL, 32'd1234, 32'd5678);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = MD_MUL; bus.op_a = 32'd1234; bus.op_b = 32'd5678;
        @(posedge clk); #1;
        bus.funct3 = MD_DIVU; bus.op_a = 32'd9; bus.op_b = 32'd0;
        dones = 0;
        for (int i = 0; i < 45; i++) begin
            if (i == 5) bus.start = 1'b0;
            if (bus.done) dones++;
            @(posedge clk); #1;
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL busy_start pulses: got %0d want 1", dones);
        end
        total++;
        if (bus.result !== exp) begin
            bad++;
            $display("FAIL busy_start result: got %h want %h", bus.result, exp);
        end
    endtask

    task automatic test_back_to_back();
        run_op(MD_MUL,  32'hFFFF_FFF0, 32'd3,         "b2b_first");
        run_op(MD_DIV,  32'd1000,      32'hFFFF_FFF9, "b2b_second");
        run_op(MD_REMU, 32'hDEAD_BEEF, 32'd1000,      "b2b_third");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_busy_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
